// File: rtl/dmem_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_pkg;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 16;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StServe = 2'd1,
        StDone  = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick; on a tie the port that was not granted last wins.
module rr_arb2
    import dmem_pkg::*;
(
    input  logic a_req,
    input  logic b_req,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_sel
);

    always_comb begin
        grant_valid = a_req | b_req;
        grant_sel   = PORT_A;
        if (a_req && b_req) begin
            grant_sel = (last_grant == PORT_A) ? PORT_B : PORT_A;
        end else if (b_req) begin
            grant_sel = PORT_B;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester sequencer for the data memory: grant, one SERVE cycle, one DONE/ack cycle.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              mem_write,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              sel_q, sel_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              mem_write_q, mem_write_d;
    logic              mem_read_q, mem_read_d;
    logic              a_ack_q, a_ack_d;
    logic              b_ack_q, b_ack_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

    logic grant_valid;
    logic grant_sel;

    rr_arb2 u_rr_arb2 (
        .a_req       (a_req),
        .b_req       (b_req),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_sel   (grant_sel)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        sel_d        = sel_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        mem_write_d  = 1'b0;
        mem_read_d   = 1'b0;
        a_ack_d      = 1'b0;
        b_ack_d      = 1'b0;
        a_rdata_d    = a_rdata_q;
        b_rdata_d    = b_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (grant_valid) begin
                    sel_d        = grant_sel;
                    we_d         = (grant_sel == PORT_B) ? b_we : a_we;
                    addr_d       = (grant_sel == PORT_B) ? b_addr : a_addr;
                    wdata_d      = (grant_sel == PORT_B) ? b_wdata : a_wdata;
                    mem_write_d  = we_d;
                    mem_read_d   = ~we_d;
                    last_grant_d = grant_sel;
                    state_d      = StServe;
                end
            end
            StServe: begin
                // Memory read is combinational, so data is valid during SERVE itself.
                if (mem_read_q) begin
                    if (sel_q == PORT_B) b_rdata_d = mem_rdata;
                    else                 a_rdata_d = mem_rdata;
                end
                a_ack_d = (sel_q == PORT_A);
                b_ack_d = (sel_q == PORT_B);
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_grant_q <= PORT_B;
            sel_q        <= PORT_A;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            mem_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            a_ack_q      <= 1'b0;
            b_ack_q      <= 1'b0;
            a_rdata_q    <= '0;
            b_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            sel_q        <= sel_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            mem_write_q  <= mem_write_d;
            mem_read_q   <= mem_read_d;
            a_ack_q      <= a_ack_d;
            b_ack_q      <= b_ack_d;
            a_rdata_q    <= a_rdata_d;
            b_rdata_q    <= b_rdata_d;
        end
    end

    assign a_ack     = a_ack_q;
    assign b_ack     = b_ack_q;
    assign a_rdata   = a_rdata_q;
    assign b_rdata   = b_rdata_q;
    assign mem_write = mem_write_q;
    assign mem_read  = mem_read_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 256x16 data memory attached.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_req = 1'b0, a_we = 1'b0;
    logic [7:0]  a_addr = '0;
    logic [15:0] a_wdata = '0;
    logic        a_ack;
    logic [15:0] a_rdata;
    logic        b_req = 1'b0, b_we = 1'b0;
    logic [7:0]  b_addr = '0;
    logic [15:0] b_wdata = '0;
    logic        b_ack;
    logic [15:0] b_rdata;
    logic        mem_write, mem_read;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic        busy;

    logic [15:0] mem [256];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = mem_read ? mem[mem_addr] : 16'h0;

    dmem_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_req     (a_req),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_ack     (a_ack),
        .a_rdata   (a_rdata),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_ack     (b_ack),
        .b_rdata   (b_rdata),
        .mem_write (mem_write),
        .mem_read  (mem_read),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("strobe_excl", 32'(mem_write && mem_read), 0);
            check("ack_overlap", 32'(a_ack && b_ack), 0);
        end
    end

    // Drives one request, waits for its ack (bounded) and drops req at the ack cycle.
    task automatic run_txn(input logic port, input logic we, input logic [7:0] addr,
                           input logic [15:0] wdata, input string tag);
        int  lat;
        logic got;
        lat = 0;
        got = 1'b0;
        @(negedge clk);
        if (port) begin
            b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata;
        end else begin
            a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata;
        end
        while (!got && lat < 8) begin
            @(negedge clk);
            lat++;
            if (port ? b_ack : a_ack) got = 1'b1;
        end
        check({tag, "_lat"}, 32'(lat), 2);
        a_req = 1'b0;
        b_req = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n, cyc, last;
        logic exp_port;

        // Reset state
        @(negedge clk);
        check("rst_a_ack", 32'(a_ack), 0);
        check("rst_b_ack", 32'(b_ack), 0);
        check("rst_a_rdata", 32'(a_rdata), 0);
        check("rst_b_rdata", 32'(b_rdata), 0);
        check("rst_mem_write", 32'(mem_write), 0);
        check("rst_mem_read", 32'(mem_read), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;

        // A write 0xBEEF to 0x10, cycle by cycle
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b1; a_addr = 8'h10; a_wdata = 16'hBEEF;
        @(negedge clk);
        check("w1_mem_write", 32'(mem_write), 1);
        check("w1_mem_read", 32'(mem_read), 0);
        check("w1_mem_addr", 32'(mem_addr), 'h10);
        check("w1_mem_wdata", 32'(mem_wdata), 'hBEEF);
        check("w1_busy", 32'(busy), 1);
        check("w1_ack_early", 32'(a_ack), 0);
        @(negedge clk);
        check("w1_mem_write_off", 32'(mem_write), 0);
        check("w1_ack", 32'(a_ack), 1);
        check("w1_rdata_hold", 32'(a_rdata), 0);
        a_req = 1'b0;
        @(negedge clk);
        check("w1_ack_off", 32'(a_ack), 0);
        check("w1_idle", 32'(busy), 0);

        run_txn(1'b0, 1'b0, 8'h10, 16'h0, "a_rd10");
        check("a_rd10_data", 32'(a_rdata), 'hBEEF);

        run_txn(1'b1, 1'b1, 8'hFF, 16'h1234, "b_wrFF");
        check("b_wrFF_rdata_hold", 32'(b_rdata), 0);
        run_txn(1'b1, 1'b0, 8'hFF, 16'h0, "b_rdFF");
        check("b_rdFF_data", 32'(b_rdata), 'h1234);
        check("a_rdata_kept", 32'(a_rdata), 'hBEEF);

        // Preloads; last one by B so A wins the following tie
        run_txn(1'b0, 1'b1, 8'h01, 16'h0A01, "pre01");
        run_txn(1'b0, 1'b1, 8'h02, 16'h0B02, "pre02");
        run_txn(1'b1, 1'b1, 8'h20, 16'h5555, "pre20");

        // Contention: both held through four transactions
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b0; a_addr = 8'h01;
        b_req = 1'b1; b_we = 1'b0; b_addr = 8'h02;
        n = 0; cyc = 0; last = 0; exp_port = 1'b0;
        while (n < 4 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (a_ack || b_ack) begin
                check("cont_order", 32'(b_ack), 32'(exp_port));
                if (a_ack) check("cont_a_data", 32'(a_rdata), 'h0A01);
                else       check("cont_b_data", 32'(b_rdata), 'h0B02);
                if (n > 0) check("cont_spacing", 32'(cyc - last), 3);
                last = cyc;
                n++;
                exp_port = ~exp_port;
            end
        end
        check("cont_count", 32'(n), 4);
        a_req = 1'b0; b_req = 1'b0;

        // A read held high: 3-cycle cadence
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b0; a_addr = 8'h10;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("held_busy", 32'(busy), 32'((k % 3) != 0));
            check("held_mem_read", 32'(mem_read), 32'((k % 3) == 1));
            check("held_ack", 32'(a_ack), 32'((k % 3) == 2));
        end
        check("held_data", 32'(a_rdata), 'hBEEF);
        a_req = 1'b0;
        @(negedge clk);
        check("held_idle", 32'(busy), 0);

        // Reset during SERVE of a write
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b1; a_addr = 8'h20; a_wdata = 16'hDEAD;
        @(negedge clk);
        check("abort_serve", 32'(mem_write), 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_wr_drop", 32'(mem_write), 0);
        check("abort_busy", 32'(busy), 0);
        a_req = 1'b0;
        @(negedge clk);
        check("abort_rdata_clr", 32'(a_rdata), 0);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort_no_ack", 32'(a_ack), 0);
        end
        run_txn(1'b0, 1'b0, 8'h20, 16'h0, "abort_rd20");
        check("abort_rd20_data", 32'(a_rdata), 'h5555);

        // A pulses for one cycle while B is in SERVE: never granted
        @(negedge clk);
        b_req = 1'b1; b_we = 1'b0; b_addr = 8'h02;
        @(negedge clk);
        check("pulse_b_serve", 32'(mem_read), 1);
        a_req = 1'b1; a_we = 1'b0; a_addr = 8'h01;
        @(negedge clk);
        check("pulse_b_ack", 32'(b_ack), 1);
        check("pulse_b_data", 32'(b_rdata), 'h0B02);
        a_req = 1'b0; b_req = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("pulse_a_ack", 32'(a_ack), 0);
            check("pulse_busy", 32'(busy), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter/sequencer in front of the 256x16 data memory (sync write, async read gated by mem_read).
- Port A serves the CPU load/store path; port B serves a debug/DMA loader.
- Each granted transaction runs a fixed 3-state sequence: the memory strobes are registered, read data is captured, and a one-cycle ack is returned.
- Round-robin tie-break prevents starvation of either port.

Parameters:
- ADDR_W, 8, memory word-address width.
- DATA_W, 16, data word width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- a_req  in  1  port A request; level, held until a_ack.
- a_we  in  1  port A write (1) / read (0); stable while a_req is high.
- a_addr  in  ADDR_W  port A address.
- a_wdata  in  DATA_W  port A write data.
- a_ack  out  1  one-cycle completion pulse to port A.
- a_rdata  out  DATA_W  port A read data; valid with a_ack, held until the next port A read ack.
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata: same as port A, for port B.
- mem_write  out  1  to data memory write enable.
- mem_read  out  1  to data memory read enable.
- mem_addr  out  ADDR_W  to data memory address.
- mem_wdata  out  DATA_W  to data memory data_in.
- mem_rdata  in  DATA_W  from data memory data_out (combinational).
- busy  out  1  high while state != IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, last_grant=B (so port A wins the first tie).
  - All outputs 0, including a_rdata and b_rdata.
  - mem_write drops immediately.
  - An in-flight transaction is aborted: no write occurs and no ack is issued.
- IDLE:
  - If no requests: stay in IDLE, all mem strobes 0.
  - If exactly one req is high: grant that port.
  - If both are high: grant the port != last_grant.
  - On grant, at the clock edge: latch sel, we, addr, wdata; drive mem_addr/mem_wdata from the latch; set mem_write=we and mem_read=~we (registered); update last_grant=sel; go to SERVE.
- SERVE (exactly 1 cycle):
  - mem strobes are high for this single cycle.
  - Write: memory commits at the edge ending SERVE.
  - Read: at the edge ending SERVE, sel_rdata <= mem_rdata.
  - At that edge, clear mem_write/mem_read, assert sel_ack, go to DONE.
- DONE (exactly 1 cycle):
  - sel_ack=1 for this cycle only.
  - Next edge: ack returns to 0, state goes to IDLE.
- Latency:
  - req first sampled high at edge N → SERVE during cycle N+1 → ack high during cycle N+2.
  - Minimum spacing between grants is 3 cycles.
- Handshake rules:
  - The requester must deassert req in the cycle after ack. If req is still high in IDLE, it is treated as a new request.
  - Command fields must be stable from req rise until the grant edge; they are latched there and may change afterwards.
  - A req that drops before being granted is simply not served; no ack is issued.
- Non-granted port: its req may stay high through SERVE/DONE and is arbitrated on the next IDLE cycle. Under contention, grants strictly alternate A,B,A,B.
- Write ack: a_rdata/b_rdata are unchanged on a write ack.
- Invariants:
  - mem_write and mem_read are never both 1.
  - mem_read=0 outside SERVE, so the memory returns 0 then.
- Width rules: addresses and data pass through unmodified. No address wrap arithmetic is done in this block.

Decomposition:
- Shared package dmem_pkg holds:
  - state encoding (IDLE=2'd0, SERVE=2'd1, DONE=2'd2);
  - port select constants (PORT_A=1'b0, PORT_B=1'b1);
  - ADDR_W/DATA_W defaults.
- One natural sub-module: rr_arb2 (combinational 2-way round-robin pick from a_req, b_req, last_grant → grant_valid, grant_sel). The FSM and latches stay in the top level.

Test Plan:
- Reset, then a_req with a_we=1, addr=0x10, wdata=0xBEEF. Expected: mem_write high exactly 1 cycle (N+1), a_ack at N+2. Then a_req read of addr 0x10 → a_rdata=0xBEEF with a_ack, 3 cycles after req.
- b_req write of 0x1234 to addr 0xFF, then b read of 0xFF → b_rdata=0x1234. a_rdata is unchanged from its previous value.
- a_req and b_req asserted together, held through 4 transactions (reads of 0x01 and 0x02, preloaded 0x0A01 and 0x0B02). Grant order A,B,A,B; acks never overlap; each ack carries the correct data.
- a_req read held high with b idle. Transactions repeat every 3 cycles, busy toggles IDLE/SERVE/DONE, and mem_read is high 1 of every 3 cycles.
- Assert rst_n=0 during SERVE of a write of 0xDEAD to 0x20, where 0x20 holds 0x5555 beforehand. mem_write drops immediately, no ack follows, and a later read of 0x20 returns 0x5555.
- Pulse a_req for 1 cycle while b's transaction is in SERVE. a is never granted and a_ack stays 0. Check the invariant !(mem_write && mem_read) every cycle.
